// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one 64-bit Wishbone-classic master port among NREQ requesters.
// Define IOARB_TIMEOUT_EN to add a watchdog that ends hung transactions with s_err_o.
`timescale 1ns/1ps

module io_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int TMO_CYCLES = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      s_cyc_i,
    input  logic [NREQ-1:0]      s_stb_i,
    input  logic [NREQ-1:0]      s_we_i,
    input  logic [NREQ*8-1:0]    s_sel_i,
    input  logic [NREQ*32-1:0]   s_adr_i,
    input  logic [NREQ*64-1:0]   s_dat_i,
    output logic [NREQ-1:0]      s_ack_o,
    output logic [NREQ-1:0]      s_err_o,
    output logic [63:0]          s_dat_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic                 m_we_o,
    output logic [7:0]           m_sel_o,
    output logic [31:0]          m_adr_o,
    output logic [63:0]          m_dat_o,
    input  logic                 m_ack_i,
    input  logic [63:0]          m_dat_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic            m_act_q, m_act_d;
    logic            m_we_q, m_we_d;
    logic [7:0]      m_sel_q, m_sel_d;
    logic [31:0]     m_adr_q, m_adr_d;
    logic [63:0]     m_dat_q, m_dat_d;
    logic [NREQ-1:0] s_ack_q, s_ack_d;
    logic [63:0]     s_dat_q, s_dat_d;

    logic [NREQ-1:0] req;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    int              idx;

    logic [7:0]      sel_a [NREQ];
    logic [31:0]     adr_a [NREQ];
    logic [63:0]     dat_a [NREQ];

    assign req = s_cyc_i & s_stb_i;

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign sel_a[k] = s_sel_i[8*k +: 8];
        assign adr_a[k] = s_adr_i[32*k +: 32];
        assign dat_a[k] = s_dat_i[64*k +: 64];
    end

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (v == IW'(NREQ - 1)) begin
            return '0;
        end
        return v + IW'(1);
    endfunction

    // First requester at or after the round-robin pointer, wrapping at NREQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_vld && req[IW'(idx)]) begin
                pick     = IW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

`ifdef IOARB_TIMEOUT_EN
    logic [9:0]      wdog_q, wdog_d;
    logic [NREQ-1:0] s_err_q, s_err_d;
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        m_act_d = m_act_q;
        m_we_d  = m_we_q;
        m_sel_d = m_sel_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;
        s_ack_d = s_ack_q;
        s_dat_d = s_dat_q;
`ifdef IOARB_TIMEOUT_EN
        wdog_d  = wdog_q;
        s_err_d = s_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    g_d     = pick;
                    m_sel_d = sel_a[pick];
                    m_adr_d = adr_a[pick];
                    m_dat_d = dat_a[pick];
                    m_we_d  = s_we_i[pick];
                    m_act_d = 1'b1;
                    state_d = ST_BUSY;
`ifdef IOARB_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                // Abort outranks a same-cycle ack; the ack is simply dropped.
                if (!s_cyc_i[g_q]) begin
                    m_act_d = 1'b0;
                    m_we_d  = 1'b0;
                    rr_d    = wrap_inc(g_q);
                    state_d = ST_IDLE;
                end else if (m_ack_i) begin
                    m_act_d = 1'b0;
                    m_we_d  = 1'b0;
                    s_ack_d = ONE << g_q;
                    s_dat_d = m_dat_i;
                    state_d = ST_HOLD;
`ifdef IOARB_TIMEOUT_EN
                end else if (wdog_q == 10'(TMO_CYCLES)) begin
                    m_act_d = 1'b0;
                    m_we_d  = 1'b0;
                    s_err_d = ONE << g_q;
                    state_d = ST_HOLD;
                end else begin
                    wdog_d  = wdog_q + 10'd1;
`endif
                end
            end
            ST_HOLD: begin
                if (!s_stb_i[g_q]) begin
                    s_ack_d = '0;
`ifdef IOARB_TIMEOUT_EN
                    s_err_d = '0;
`endif
                    rr_d    = wrap_inc(g_q);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            m_act_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_sel_q <= '0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            s_ack_q <= '0;
            s_dat_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            m_act_q <= m_act_d;
            m_we_q  <= m_we_d;
            m_sel_q <= m_sel_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
            s_ack_q <= s_ack_d;
            s_dat_q <= s_dat_d;
        end
    end

`ifdef IOARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q  <= '0;
            s_err_q <= '0;
        end else begin
            wdog_q  <= wdog_d;
            s_err_q <= s_err_d;
        end
    end
    assign s_err_o = s_err_q;
`else
    assign s_err_o = '0;
`endif

    assign s_ack_o = s_ack_q;
    assign s_dat_o = s_dat_q;
    assign m_cyc_o = m_act_q;
    assign m_stb_o = m_act_q;
    assign m_we_o  = m_we_q;
    assign m_sel_o = m_sel_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;

    a_params: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (NREQ >= 2) && (NREQ <= 8) && (TMO_CYCLES >= 1) && (TMO_CYCLES <= 1023));

    a_resp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(s_ack_o | s_err_o) && ((s_ack_o & s_err_o) == '0));

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized request batches.
`timescale 1ns/1ps

module tb_io_bus_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NREQ-1:0]     s_cyc_i, s_stb_i, s_we_i;
  logic [NREQ*8-1:0]   s_sel_i;
  logic [NREQ*32-1:0]  s_adr_i;
  logic [NREQ*64-1:0]  s_dat_i;
  logic [NREQ-1:0]     s_ack_o, s_err_o;
  logic [63:0]         s_dat_o;
  logic                m_cyc_o, m_stb_o, m_we_o;
  logic [7:0]          m_sel_o;
  logic [31:0]         m_adr_o;
  logic [63:0]         m_dat_o;
  logic                m_ack_i;
  logic [63:0]         m_dat_i;

  io_bus_arbiter #(.NREQ(NREQ), .TMO_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
  );

  // clock
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // reference model state
  int          model_rr;
  logic [31:0] r_adr [NREQ];
  logic [7:0]  r_sel [NREQ];
  logic [63:0] r_dat [NREQ];
  logic        r_we  [NREQ];
  logic [2:0]  exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int k);
    logic [63:0] v;
    v = 64'd1;
    return v << k;
  endfunction

  task automatic set_req(input int k, input logic on);
    s_cyc_i[k]           = on;
    s_stb_i[k]           = on;
    s_we_i[k]            = r_we[k];
    s_sel_i[8*k +: 8]    = r_sel[k];
    s_adr_i[32*k +: 32]  = r_adr[k];
    s_dat_i[64*k +: 64]  = r_dat[k];
  endtask

  task automatic rand_fields(input int k);
    r_adr[k] = $urandom;
    r_sel[k] = 8'($urandom_range(0, 255));
    r_dat[k] = {$urandom, $urandom};
    r_we[k]  = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_inputs();
    s_cyc_i = '0; s_stb_i = '0; s_we_i = '0;
    s_sel_i = '0; s_adr_i = '0; s_dat_i = '0;
    m_ack_i = 1'b0; m_dat_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    model_rr = 0;
    @(negedge clk_i);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (!m_cyc_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!m_cyc_o) check(tag, 64'(m_cyc_o), 64'd1);
  endtask

  // Serves nserve transactions from the requesters in mask; with rereq the
  // served requester asks again right after its handshake completes.
  task automatic run_batch(input logic [NREQ-1:0] mask, input int nserve, input bit rereq);
    logic [NREQ-1:0] pend;
    int rr, cur, served, cyc, wait_n, reraise, pick;
    bit in_txn, acked;
    logic [63:0] rdata;
    pend = mask;
    rr = model_rr;
    exp_q.delete();
    for (int n = 0; n < nserve; n++) begin
      pick = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (pick < 0 && pend[(rr + i) % NREQ]) pick = (rr + i) % NREQ;
      end
      exp_q.push_back(3'(pick));
      rr = (pick + 1) % NREQ;
      if (!rereq) pend[pick] = 1'b0;
    end
    model_rr = rr;
    for (int k = 0; k < NREQ; k++) begin
      if (mask[k]) begin
        rand_fields(k);
        set_req(k, 1'b1);
      end
    end
    cur = 0; served = 0; cyc = 0; wait_n = 0; reraise = -1;
    in_txn = 0; acked = 0; rdata = '0;
    while (served < nserve && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      m_ack_i = 1'b0;
      if (reraise >= 0) begin
        s_stb_i[reraise] = 1'b1;
        reraise = -1;
      end
      if (in_txn && acked) begin
        check("ack_onehot", 64'(s_ack_o), onehot(cur));
        check("ack_rdata", s_dat_o, rdata);
        served++;
        in_txn = 0;
        acked = 0;
        if (served == nserve) begin
          s_cyc_i = '0;
          s_stb_i = '0;
        end else if (rereq) begin
          s_stb_i[cur] = 1'b0;
          reraise = cur;
        end else begin
          set_req(cur, 1'b0);
        end
      end else if (!in_txn && m_cyc_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 64'(m_cyc_o), 64'd0);
        end else begin
          cur = int'(exp_q.pop_front());
          check("gnt_adr", 64'(m_adr_o), 64'(r_adr[cur]));
          check("gnt_sel", 64'(m_sel_o), 64'(r_sel[cur]));
          check("gnt_dat", m_dat_o, r_dat[cur]);
          check("gnt_we", 64'(m_we_o), 64'(r_we[cur]));
          check("gnt_stb", 64'(m_stb_o), 64'd1);
          in_txn = 1;
          wait_n = $urandom_range(0, 3);
        end
      end
      if (in_txn && !acked) begin
        if (wait_n == 0) begin
          rdata = {$urandom, $urandom};
          m_dat_i = rdata;
          m_ack_i = 1'b1;
          acked = 1;
        end else begin
          wait_n--;
        end
      end
    end
    if (served < nserve) check("batch_served", 64'(served), 64'(nserve));
    m_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("idle_after_batch", 64'(m_cyc_o), 64'd0);
  endtask

  initial begin
    int n;
    logic [NREQ-1:0] mask;
    clear_inputs();
    rst_ni = 1'b0;
    #1;
    check("rst_m_cyc", 64'(m_cyc_o), 64'd0);
    check("rst_s_ack", 64'(s_ack_o), 64'd0);
    check("rst_s_dat", s_dat_o, 64'd0);
    do_reset();
    check("post_rst_outputs", {m_adr_o, 8'(m_sel_o), 8'(s_ack_o), 8'(s_err_o), 5'd0, m_cyc_o, m_stb_o, m_we_o}, 64'd0);

    // reset while BUSY, then single requester 2
    r_adr[2] = 32'hC000_0204; r_sel[2] = 8'h0F; r_dat[2] = 64'h0102_0304_0506_0708; r_we[2] = 1'b1;
    set_req(2, 1'b1);
    wait_grant("t1_grant_timeout");
    check("t1_busy_adr", 64'(m_adr_o), 64'(r_adr[2]));
    #2 rst_ni = 1'b0;
    #1;
    check("t1_async_cyc", 64'(m_cyc_o), 64'd0);
    check("t1_async_adr", 64'(m_adr_o), 64'd0);
    check("t1_async_dat", m_dat_o, 64'd0);
    check("t1_async_we", 64'(m_we_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("t1_rel_cyc", 64'(m_cyc_o), 64'd0);
    @(negedge clk_i);
    check("t1_latency_cyc", 64'(m_cyc_o), 64'd1);
    check("t1_latency_adr", 64'(m_adr_o), 64'(r_adr[2]));

    // round robin with everyone re-requesting: 0,1,2,3,0
    do_reset();
    run_batch(4'b1111, 5, 1'b1);

    // read from requester 1
    do_reset();
    r_adr[1] = 32'hFFDC_0010; r_sel[1] = 8'hFF; r_dat[1] = '0; r_we[1] = 1'b0;
    set_req(1, 1'b1);
    wait_grant("t3_grant_timeout");
    check("t3_adr", 64'(m_adr_o), 64'hFFDC_0010);
    check("t3_we", 64'(m_we_o), 64'd0);
    m_dat_i = 64'h1122_3344_5566_7788;
    m_ack_i = 1'b1;
    @(negedge clk_i);
    m_ack_i = 1'b0;
    check("t3_ack", 64'(s_ack_o), 64'b0010);
    check("t3_rdata", s_dat_o, 64'h1122_3344_5566_7788);
    check("t3_cyc_drop", 64'(m_cyc_o), 64'd0);
    repeat (3) @(negedge clk_i);
    check("t3_ack_held", 64'(s_ack_o), 64'b0010);
    set_req(1, 1'b0);
    @(negedge clk_i);
    check("t3_ack_release", 64'(s_ack_o), 64'd0);

    // abort coinciding with ack, then search restarts at 0
    do_reset();
    rand_fields(3);
    set_req(3, 1'b1);
    wait_grant("t4_grant_timeout");
    check("t4_adr", 64'(m_adr_o), 64'(r_adr[3]));
    s_cyc_i[3] = 1'b0;
    m_ack_i = 1'b1;
    m_dat_i = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk_i);
    m_ack_i = 1'b0;
    check("t4_no_ack", 64'(s_ack_o), 64'd0);
    check("t4_cyc_drop", 64'(m_cyc_o), 64'd0);
    rand_fields(0);
    rand_fields(3);
    set_req(0, 1'b1);
    set_req(3, 1'b1);
    @(negedge clk_i);
    check("t4_regrant_cyc", 64'(m_cyc_o), 64'd1);
    check("t4_regrant_adr", 64'(m_adr_o), 64'(r_adr[0]));

    // watchdog
    do_reset();
    rand_fields(1);
    set_req(1, 1'b1);
    wait_grant("t5_grant_timeout");
`ifdef IOARB_TIMEOUT_EN
    n = 1;
    while (s_err_o == '0 && n < 50) begin
      @(negedge clk_i);
      if (s_err_o == '0) n++;
    end
    check("t5_busy_cycles", 64'(n), 64'(TMO + 1));
    check("t5_err", 64'(s_err_o), 64'b0010);
    check("t5_cyc_drop", 64'(m_cyc_o), 64'd0);
    check("t5_no_ack", 64'(s_ack_o), 64'd0);
`else
    n = 0;
    repeat (2000) @(negedge clk_i);
    check("t5_still_busy", 64'(m_cyc_o), 64'd1);
    check("t5_no_err", 64'(s_err_o), 64'd0);
    check("t5_no_ack", 64'(s_ack_o), 64'd0);
`endif

    // write from requester 0
    do_reset();
    r_adr[0] = 32'h4000_0100; r_sel[0] = 8'hF0; r_dat[0] = 64'hAABB_CCDD_EEFF_0011; r_we[0] = 1'b1;
    set_req(0, 1'b1);
    wait_grant("t6_grant_timeout");
    check("t6_we", 64'(m_we_o), 64'd1);
    check("t6_sel", 64'(m_sel_o), 64'hF0);
    check("t6_dat", m_dat_o, 64'hAABB_CCDD_EEFF_0011);
    m_dat_i = 64'h5555_0000_5555_0000;
    m_ack_i = 1'b1;
    @(negedge clk_i);
    m_ack_i = 1'b0;
    check("t6_ack", 64'(s_ack_o), 64'b0001);
    check("t6_we_clear", 64'(m_we_o), 64'd0);
    check("t6_sel_hold", 64'(m_sel_o), 64'hF0);
    set_req(0, 1'b0);

    // randomized batches, round-robin pointer carried by the model
    do_reset();
    for (int b = 0; b < 25; b++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      if (b % 5 == 4) run_batch(mask, $urandom_range(2, 7), 1'b1);
      else run_batch(mask, $countones(mask), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
